// File: rtl/cpu_dmem_responder.sv
// cpu_dmem_responder
//   Data-memory responder for the execute stage. Each word request is decoded
//   to on-chip RAM, the LED register, the switch inputs, the free-running
//   cycle counter, or the external slow region. Fast targets answer with a
//   one-cycle load latency and never stall. External accesses go out over a
//   req/ack handshake and stall the pipeline until ack or timeout.
// Ports
//   clk, reset            clock (rising edge), async active-low reset
//   i_mem_*               request from execute: byte addr, store data, wr, rd
//   o_stall               hold execute; request inputs stay stable while high
//   o_rd_data/o_rd_valid  load result, valid for one cycle after acceptance
//   i_sw / o_ledr         switch inputs / LED register
//   o_ext_*, i_ext_*      external slow-region handshake
//   o_err                 sticky external timeout flag
module cpu_dmem_responder #(
    parameter int RAM_WORDS   = 256,
    parameter int SW_WIDTH    = 10,
    parameter int EXT_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         i_mem_addr,
    input  logic [15:0]         i_mem_data,
    input  logic                i_mem_wr,
    input  logic                i_mem_rd,
    output logic                o_stall,
    output logic [15:0]         o_rd_data,
    output logic                o_rd_valid,
    input  logic [SW_WIDTH-1:0] i_sw,
    output logic [15:0]         o_ledr,
    output logic                o_ext_req,
    output logic                o_ext_we,
    output logic [15:0]         o_ext_addr,
    output logic [15:0]         o_ext_wdata,
    input  logic                i_ext_ack,
    input  logic [15:0]         i_ext_rdata,
    output logic                o_err
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int TW = $clog2(EXT_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(EXT_TIMEOUT - 1);

    localparam logic [15:0] LED_ADDR = 16'h1000;
    localparam logic [15:0] SW_ADDR  = 16'h1002;
    localparam logic [15:0] CYC_ADDR = 16'h1004;

    typedef enum logic {IDLE, EXT_WAIT} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] wcnt_q;
    logic [15:0]   cyc_q;
    logic [15:0]   ram [RAM_WORDS];

    logic          sel_ram, sel_led, sel_sw, sel_cyc, sel_ext;
    logic          req_any, fast_we, fast_rd;
    logic          ext_start, ext_done, ext_tmo, stall_raw;
    logic [AW-1:0] ram_idx;
    logic [15:0]   fast_rdata;

    // Address decode; bit 0 is ignored everywhere (word accesses only).
    assign sel_ram = (i_mem_addr[15:12] == 4'h0);
    assign sel_led = (i_mem_addr[15:1] == LED_ADDR[15:1]);
    assign sel_sw  = (i_mem_addr[15:1] == SW_ADDR[15:1]);
    assign sel_cyc = (i_mem_addr[15:1] == CYC_ADDR[15:1]);
    assign sel_ext = (i_mem_addr[15:12] == 4'h2);
    assign ram_idx = i_mem_addr[AW:1];

    assign req_any = i_mem_wr | i_mem_rd;
    // Fast accesses are accepted only in IDLE; a store wins over a load.
    assign fast_we = (state_q == IDLE) & ~sel_ext & i_mem_wr;
    assign fast_rd = (state_q == IDLE) & ~sel_ext & i_mem_rd & ~i_mem_wr;

    // Stall drops immediately while reset is asserted, even if execute is
    // still presenting an external request.
    assign o_stall = stall_raw & reset;

    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        ext_start = 1'b0;
        ext_done  = 1'b0;
        ext_tmo   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any && sel_ext) begin
                    stall_raw = 1'b1;
                    ext_start = 1'b1;
                    state_d   = EXT_WAIT;
                end
            end
            EXT_WAIT: begin
                // An ack in the last allowed cycle still counts as success.
                if (i_ext_ack) begin
                    ext_done = 1'b1;
                    state_d  = IDLE;
                end else if (wcnt_q == TMO_LAST) begin
                    ext_tmo = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fast_rdata = '0;
        if (sel_ram)      fast_rdata = ram[ram_idx];
        else if (sel_led) fast_rdata = o_ledr;
        else if (sel_sw)  fast_rdata = 16'(i_sw);
        else if (sel_cyc) fast_rdata = cyc_q;
    end

    // RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (fast_we && sel_ram) ram[ram_idx] <= i_mem_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            cyc_q       <= '0;
            o_ledr      <= '0;
            o_rd_data   <= '0;
            o_rd_valid  <= 1'b0;
            o_ext_req   <= 1'b0;
            o_ext_we    <= 1'b0;
            o_ext_addr  <= '0;
            o_ext_wdata <= '0;
            o_err       <= 1'b0;
        end else begin
            state_q    <= state_d;
            o_rd_valid <= 1'b0;

            // A counter write replaces that edge's increment.
            if (fast_we && sel_cyc) cyc_q <= i_mem_data;
            else                    cyc_q <= cyc_q + 16'd1;

            if (fast_we && sel_led) o_ledr <= i_mem_data;

            if (fast_rd) begin
                o_rd_valid <= 1'b1;
                o_rd_data  <= fast_rdata;
            end

            if (ext_start) begin
                o_ext_req   <= 1'b1;
                o_ext_we    <= i_mem_wr;
                o_ext_addr  <= i_mem_addr;
                o_ext_wdata <= i_mem_data;
                wcnt_q      <= '0;
            end else if (state_q == EXT_WAIT) begin
                wcnt_q <= wcnt_q + TW'(1);
            end

            if (ext_done || ext_tmo) begin
                o_ext_req <= 1'b0;
                if (!o_ext_we) begin
                    o_rd_valid <= 1'b1;
                    o_rd_data  <= ext_done ? i_ext_rdata : 16'hDEAD;
                end
            end

            if (ext_tmo) o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_dmem_responder.sv
module tb_cpu_dmem_responder;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] i_mem_addr = '0;
    logic [15:0] i_mem_data = '0;
    logic        i_mem_wr = 1'b0;
    logic        i_mem_rd = 1'b0;
    logic        o_stall;
    logic [15:0] o_rd_data;
    logic        o_rd_valid;
    logic [9:0]  i_sw = '0;
    logic [15:0] o_ledr;
    logic        o_ext_req;
    logic        o_ext_we;
    logic [15:0] o_ext_addr;
    logic [15:0] o_ext_wdata;
    logic        i_ext_ack = 1'b0;
    logic [15:0] i_ext_rdata = '0;
    logic        o_err;

    cpu_dmem_responder #(.RAM_WORDS(256), .SW_WIDTH(10), .EXT_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
        .i_mem_wr(i_mem_wr), .i_mem_rd(i_mem_rd),
        .o_stall(o_stall), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .i_sw(i_sw), .o_ledr(o_ledr),
        .o_ext_req(o_ext_req), .o_ext_we(o_ext_we), .o_ext_addr(o_ext_addr),
        .o_ext_wdata(o_ext_wdata), .i_ext_ack(i_ext_ack), .i_ext_rdata(i_ext_rdata),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_edges = 0;
    always @(posedge clk) n_edges <= n_edges + 1;

    int total = 0;
    int bad = 0;

    // Reference model: RAM word array, LED value, and the cycle counter as
    // "value V loaded at edge E" so its reading is V + (edges since E).
    logic [15:0] mdl_ram [256];
    logic [15:0] mdl_led;
    logic [15:0] cyc_base;
    int          cyc_edge;

    task automatic model_reset();
        mdl_led  = 16'h0;
        cyc_base = 16'h0;
        cyc_edge = n_edges;
    endtask

    function automatic logic [15:0] mdl_read(input logic [15:0] a);
        if (a[15:12] == 4'h0)       return mdl_ram[a[8:1]];
        if (a[15:1] == 15'h0800)    return mdl_led;
        if (a[15:1] == 15'h0801)    return {6'b0, i_sw};
        if (a[15:1] == 15'h0802)    return cyc_base + 16'(n_edges - cyc_edge);
        return 16'h0;
    endfunction

    // Called during the cycle of the store; it takes effect at the coming edge.
    task automatic mdl_write(input logic [15:0] a, input logic [15:0] d);
        if (a[15:12] == 4'h0)         mdl_ram[a[8:1]] = d;
        else if (a[15:1] == 15'h0800) mdl_led = d;
        else if (a[15:1] == 15'h0802) begin
            cyc_base = d;
            cyc_edge = n_edges + 1;
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [15:0] a, input logic [15:0] d);
        i_mem_wr = wr; i_mem_rd = rd; i_mem_addr = a; i_mem_data = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", o_rd_valid); end
        total++; if (o_rd_data !== 16'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0000", o_rd_data); end
        total++; if (o_ledr !== 16'h0) begin bad++; $display("FAIL reset_ledr got=%h exp=0000", o_ledr); end
        total++; if ({o_ext_req, o_ext_we, o_ext_addr, o_ext_wdata} !== 34'h0)
            begin bad++; $display("FAIL reset_ext got=%b%b %h %h exp=all zero", o_ext_req, o_ext_we, o_ext_addr, o_ext_wdata); end
        total++; if ({o_err, o_stall} !== 2'b00) begin bad++; $display("FAIL reset_err_stall got=%b%b exp=00", o_err, o_stall); end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_ram_basic();
        int stall_n = 0;
        @(negedge clk); drive(1'b1, 1'b0, 16'h0010, 16'h1234); mdl_write(16'h0010, 16'h1234);
        #1 if (o_stall) stall_n++;
        @(negedge clk);
        total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL ram_store_no_valid got=%b exp=0", o_rd_valid); end
        drive(1'b0, 1'b1, 16'h0010, 16'h0);
        #1 if (o_stall) stall_n++;
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 16'h0);
        total++; if (o_rd_valid !== 1'b1) begin bad++; $display("FAIL ram_load_valid got=%b exp=1", o_rd_valid); end
        total++; if (o_rd_data !== 16'h1234) begin bad++; $display("FAIL ram_load_data got=%h exp=1234", o_rd_data); end
        total++; if (stall_n !== 0) begin bad++; $display("FAIL ram_stall got=%0d exp=0", stall_n); end
    endtask

    task automatic test_led_sw();
        @(negedge clk); drive(1'b1, 1'b0, 16'h1000, 16'h03FF); mdl_write(16'h1000, 16'h03FF);
        @(negedge clk);
        total++; if (o_ledr !== 16'h03FF) begin bad++; $display("FAIL led_write got=%h exp=03FF", o_ledr); end
        i_sw = 10'h2A5; drive(1'b0, 1'b1, 16'h1002, 16'h0);
        @(negedge clk);
        i_sw = 10'h000; drive(1'b1, 1'b0, 16'h1002, 16'hFFFF);   // store to SW is dropped
        total++; if (o_rd_data !== 16'h02A5 || o_rd_valid !== 1'b1)
            begin bad++; $display("FAIL sw_read got=%h/%b exp=02A5/1", o_rd_data, o_rd_valid); end
        @(negedge clk); drive(1'b0, 1'b1, 16'h3000, 16'h0);
        total++; if (o_ledr !== 16'h03FF) begin bad++; $display("FAIL sw_write_dropped led got=%h exp=03FF", o_ledr); end
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 16'h0);
        total++; if (o_rd_data !== 16'h0 || o_rd_valid !== 1'b1)
            begin bad++; $display("FAIL unmapped_read got=%h/%b exp=0000/1", o_rd_data, o_rd_valid); end
    endtask

    task automatic test_cycle();
        @(negedge clk); drive(1'b1, 1'b0, 16'h1004, 16'hFFFE); mdl_write(16'h1004, 16'hFFFE);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk); drive(1'b0, 1'b1, 16'h1004, 16'h0);
        @(negedge clk); drive(1'b0, 1'b1, 16'h1004, 16'h0);
        total++; if (o_rd_data !== 16'hFFFF) begin bad++; $display("FAIL cycle_before_wrap got=%h exp=FFFF", o_rd_data); end
        @(negedge clk); drive(1'b1, 1'b1, 16'h0020, 16'h7777); mdl_write(16'h0020, 16'h7777);
        total++; if (o_rd_data !== 16'h0000 || o_rd_valid !== 1'b1)
            begin bad++; $display("FAIL cycle_wrap got=%h/%b exp=0000/1", o_rd_data, o_rd_valid); end
        @(negedge clk); drive(1'b0, 1'b1, 16'h0020, 16'h0);
        total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL wr_rd_no_valid got=%b exp=0", o_rd_valid); end
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 16'h0);
        total++; if (o_rd_data !== 16'h7777) begin bad++; $display("FAIL wr_rd_stored got=%h exp=7777", o_rd_data); end
    endtask

    task automatic test_random_fast();
        logic [15:0] unm [4];
        logic        exp_v = 1'b0;
        logic [15:0] exp_d = '0;
        unm[0] = 16'h1006; unm[1] = 16'h3000; unm[2] = 16'hFFFE; unm[3] = 16'h1FFE;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 16'(i * 2), 16'($urandom));
            mdl_write(i_mem_addr, i_mem_data);
        end
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            int k;
            int op;
            @(negedge clk);
            total++; if (o_rd_valid !== exp_v) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, o_rd_valid, exp_v); end
            if (exp_v) begin
                total++; if (o_rd_data !== exp_d) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, o_rd_data, exp_d); end
            end
            k  = $urandom_range(0, 9);
            op = $urandom_range(0, 3);
            if (k <= 4)      a = 16'($urandom_range(0, 16'h0FFF));
            else if (k == 5) a = 16'h1000 | 16'($urandom_range(0, 1));
            else if (k == 6) a = 16'h1002;
            else if (k == 7) a = 16'h1004;
            else             a = unm[$urandom_range(0, 3)];
            i_sw = 10'($urandom);
            drive(op[0], op[1], a, 16'($urandom));
            exp_v = (op == 2);
            exp_d = mdl_read(a);
            if (op[0]) mdl_write(a, i_mem_data);
            #1 total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL rnd_stall[%0d] got=%b exp=0", i, o_stall); end
        end
        @(negedge clk);
        total++; if (o_rd_valid !== exp_v) begin bad++; $display("FAIL rnd_valid_last got=%b exp=%b", o_rd_valid, exp_v); end
        if (exp_v) begin
            total++; if (o_rd_data !== exp_d) begin bad++; $display("FAIL rnd_data_last got=%h exp=%h", o_rd_data, exp_d); end
        end
        total++; if (o_ledr !== mdl_led) begin bad++; $display("FAIL rnd_ledr got=%h exp=%h", o_ledr, mdl_led); end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic test_ext_load();
        int stall_n = 0;
        int req_n = 0;
        logic [15:0] exp_c;
        @(negedge clk); drive(1'b0, 1'b1, 16'h2004, 16'h0);
        #1 begin if (o_stall) stall_n++; if (o_ext_req) req_n++; end
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            if (w == 0) begin
                total++; if (o_ext_addr !== 16'h2004 || o_ext_we !== 1'b0)
                    begin bad++; $display("FAIL extld_addr got=%h/%b exp=2004/0", o_ext_addr, o_ext_we); end
            end
            if (w == 3) begin i_ext_ack = 1'b1; i_ext_rdata = 16'hBEEF; end
            #1 begin if (o_stall) stall_n++; if (o_ext_req) req_n++; end
        end
        @(negedge clk); i_ext_ack = 1'b0; i_ext_rdata = 16'h0; drive(1'b0, 1'b0, 16'h0, 16'h0);
        total++; if (o_rd_valid !== 1'b1 || o_rd_data !== 16'hBEEF)
            begin bad++; $display("FAIL extld_data got=%h/%b exp=BEEF/1", o_rd_data, o_rd_valid); end
        total++; if (o_ext_req !== 1'b0) begin bad++; $display("FAIL extld_req_drop got=%b exp=0", o_ext_req); end
        total++; if (stall_n !== 4) begin bad++; $display("FAIL extld_stall_cycles got=%0d exp=4", stall_n); end
        total++; if (req_n !== 4) begin bad++; $display("FAIL extld_req_cycles got=%0d exp=4", req_n); end
        // The counter kept running through the stall.
        @(negedge clk); drive(1'b0, 1'b1, 16'h1004, 16'h0); exp_c = mdl_read(16'h1004);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 16'h0);
        total++; if (o_rd_data !== exp_c) begin bad++; $display("FAIL cycle_after_stall got=%h exp=%h", o_rd_data, exp_c); end
    endtask

    task automatic test_ext_store();
        @(negedge clk); drive(1'b1, 1'b1, 16'h2010, 16'h5A5A);
        @(negedge clk); i_ext_ack = 1'b1; i_ext_rdata = 16'h1111;
        total++; if (o_ext_req !== 1'b1 || o_ext_we !== 1'b1 || o_ext_addr !== 16'h2010 || o_ext_wdata !== 16'h5A5A)
            begin bad++; $display("FAIL extst_port got=%b%b %h %h exp=11 2010 5A5A", o_ext_req, o_ext_we, o_ext_addr, o_ext_wdata); end
        #1 total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL extst_ack_stall got=%b exp=0", o_stall); end
        @(negedge clk); i_ext_ack = 1'b0; drive(1'b0, 1'b0, 16'h0, 16'h0);
        total++; if (o_rd_valid !== 1'b0 || o_ext_req !== 1'b0)
            begin bad++; $display("FAIL extst_done got=valid %b req %b exp=0 0", o_rd_valid, o_ext_req); end
    endtask

    task automatic test_timeout();
        int stall_n = 0;
        @(negedge clk); drive(1'b0, 1'b1, 16'h2000, 16'h0);
        #1 if (o_stall) stall_n++;
        for (int w = 0; w < TMO; w++) begin
            @(negedge clk);
            #1 if (o_stall) stall_n++;
            if (w == TMO - 1) begin
                total++; if (o_stall !== 1'b0 || o_ext_req !== 1'b1)
                    begin bad++; $display("FAIL tmo_last_cycle got=stall %b req %b exp=0 1", o_stall, o_ext_req); end
            end
        end
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 16'h0); i_ext_ack = 1'b1; i_ext_rdata = 16'h4444;
        total++; if (stall_n !== TMO) begin bad++; $display("FAIL tmo_stall_cycles got=%0d exp=%0d", stall_n, TMO); end
        total++; if (o_rd_valid !== 1'b1 || o_rd_data !== 16'hDEAD)
            begin bad++; $display("FAIL tmo_data got=%h/%b exp=DEAD/1", o_rd_data, o_rd_valid); end
        total++; if (o_err !== 1'b1 || o_ext_req !== 1'b0)
            begin bad++; $display("FAIL tmo_err got=err %b req %b exp=1 0", o_err, o_ext_req); end
        @(negedge clk); i_ext_ack = 1'b0; i_ext_rdata = 16'h0;
        total++; if (o_rd_valid !== 1'b0 || o_rd_data !== 16'hDEAD)
            begin bad++; $display("FAIL tmo_late_ack got=%h/%b exp=DEAD/0", o_rd_data, o_rd_valid); end
        @(negedge clk);
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky got=%b exp=1", o_err); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_d;
        @(negedge clk); drive(1'b0, 1'b1, 16'h2000, 16'h0);
        @(negedge clk); @(negedge clk);
        total++; if (o_ext_req !== 1'b1 || o_err !== 1'b1)
            begin bad++; $display("FAIL rstmid_pre got=req %b err %b exp=1 1", o_ext_req, o_err); end
        #2 reset = 1'b0;
        #1;
        total++; if (o_ext_req !== 1'b0 || o_stall !== 1'b0 || o_err !== 1'b0)
            begin bad++; $display("FAIL rstmid_async got=req %b stall %b err %b exp=0 0 0", o_ext_req, o_stall, o_err); end
        total++; if (o_ext_addr !== 16'h0 || o_rd_valid !== 1'b0)
            begin bad++; $display("FAIL rstmid_clear got=addr %h valid %b exp=0000 0", o_ext_addr, o_rd_valid); end
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk); reset = 1'b1; model_reset();
        @(negedge clk); drive(1'b0, 1'b1, 16'h0010, 16'h0); exp_d = mdl_read(16'h0010);
        #1 total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL rstmid_next_stall got=%b exp=0", o_stall); end
        @(negedge clk); drive(1'b0, 1'b0, 16'h0, 16'h0);
        total++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp_d)
            begin bad++; $display("FAIL rstmid_next_load got=%h/%b exp=%h/1", o_rd_data, o_rd_valid, exp_d); end
        total++; if (o_ledr !== 16'h0) begin bad++; $display("FAIL rstmid_ledr got=%h exp=0000", o_ledr); end
    endtask

    initial begin
        test_reset();
        test_ram_basic();
        test_led_sw();
        test_cycle();
        test_random_fast();
        test_ext_load();
        test_ext_store();
        test_timeout();
        test_reset_mid();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
